// File: rtl/fpga_spi_regif.sv
// SPI mode-0 slave (LSB first) that turns opcode/address + data bytes into a
// single-cycle register bus with auto-incrementing address and read prefetch.
module fpga_spi_regif #(
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  spi_nss,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [7:0]            reg_rdata,
  output logic                  active
);

  typedef enum logic [1:0] {IDLE, OPCODE, WRITE, READ} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] nss_sync, sck_sync, mosi_sync;
  logic                   nss_prev, sck_prev;
  logic                   nss_s, sck_s, mosi_s;
  logic                   sck_rise, sck_fall, nss_fall, nss_rise;
  logic                   byte_done;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx;
  logic [7:0]             rx_byte;
  logic [7:0]             tx;
  logic                   wr_pend, rd_pend;

  // NOTE: nss resets low on purpose so a chip select already held low when
  // reset releases never looks like a falling edge; it must go high first.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      nss_sync  <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      nss_prev  <= 1'b0;
      sck_prev  <= 1'b0;
    end else begin
      nss_sync  <= {nss_sync[SYNC_STAGES-2:0], spi_nss};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      nss_prev  <= nss_s;
      sck_prev  <= sck_s;
    end
  end

  assign nss_s     = nss_sync[SYNC_STAGES-1];
  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev;
  assign sck_fall  = ~sck_s & sck_prev;
  assign nss_fall  = ~nss_s & nss_prev;
  assign nss_rise  = nss_s & ~nss_prev;
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  // Only seven bits are stored; the eighth arrives with the completing edge.
  assign rx_byte   = {mosi_s, rx};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      rx          <= '0;
      tx          <= '0;
      wr_pend     <= 1'b0;
      rd_pend     <= 1'b0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      active      <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      // Strobes scheduled last cycle always issue, even across nss_rise.
      reg_wr  <= wr_pend;
      reg_rd  <= rd_pend;
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;

      // A fall at count 0 would eat bit 0 of a freshly loaded byte.
      if (reg_rd)
        tx <= reg_rdata;
      else if (sck_fall && bit_cnt != 3'd0)
        tx <= {1'b0, tx[7:1]};

      if (state != IDLE && sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx      <= rx_byte[7:1];
      end

      if (reg_wr)
        reg_addr <= reg_addr + ADDR_WIDTH'(1);

      case (state)
        IDLE: begin
          if (nss_fall) begin
            state       <= OPCODE;
            bit_cnt     <= 3'd0;
            active      <= 1'b1;
            spi_miso_oe <= 1'b1;
            spi_miso    <= 1'b0;
          end
        end
        default: begin
          if (nss_rise) begin
            state       <= IDLE;
            active      <= 1'b0;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
          end else begin
            spi_miso <= (state == READ) ? tx[0] : 1'b0;
            if (byte_done) begin
              case (state)
                OPCODE: begin
                  reg_addr <= rx_byte[ADDR_WIDTH-1:0];
                  state    <= rx_byte[7] ? WRITE : READ;
                  rd_pend  <= ~rx_byte[7];
                end
                WRITE: begin
                  reg_wdata <= rx_byte;
                  wr_pend   <= 1'b1;
                end
                READ: begin
                  reg_addr <= reg_addr + ADDR_WIDTH'(1);
                  rd_pend  <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_spi_regif.sv
// Bench for fpga_spi_regif: an SPI master at clk = 12x SCK drives table vectors
// and corner sequences; a monitor logs register-bus strobes for comparison.
module tb_fpga_spi_regif;

  localparam int AW   = 7;
  localparam int SS   = 2;
  localparam int HALF = 6;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          spi_nss = 1'b1;
  logic          spi_sck = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_miso, spi_miso_oe;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_wr, reg_rd;
  logic [7:0]    reg_rdata;
  logic          active;

  fpga_spi_regif #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .spi_nss     (spi_nss),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_wr      (reg_wr),
    .reg_rd      (reg_rd),
    .reg_rdata   (reg_rdata),
    .active      (active)
  );

  always #5 clk = ~clk;

  // Register file: each location reads back as its address plus 0xA0.
  assign reg_rdata = {1'b0, reg_addr} + 8'hA0;

  typedef struct {
    string       name;
    logic [31:0] mosi;      // byte k at [k*8 +: 8]
    int          nbytes;
    logic [31:0] miso;      // expected MISO byte per transferred byte
    int          n_wr;
    logic [15:0] wr_addr;   // k-th write address at [k*8 +: 8]
    logic [15:0] wr_data;
    int          n_rd;
    logic [23:0] rd_addr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int last_wr_cyc = 0;
  int last_rd_cyc = 0;
  int excl_err = 0;
  int width_err = 0;
  int oe_bad = 0;
  logic idle_watch = 1'b0;
  logic prev_wr = 1'b0;
  logic prev_rd = 1'b0;
  logic [14:0] wr_q[$];
  logic [6:0]  rd_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reg_wr) begin
      wr_q.push_back({reg_addr, reg_wdata});
      last_wr_cyc = cyc;
    end
    if (reg_rd) begin
      rd_q.push_back(reg_addr);
      last_rd_cyc = cyc;
    end
    if (reg_wr && reg_rd) excl_err++;
    if ((reg_wr && prev_wr) || (reg_rd && prev_rd)) width_err++;
    prev_wr = reg_wr;
    prev_rd = reg_rd;
    if (idle_watch && spi_miso_oe) oe_bad++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0, LSB first; MISO is sampled just before each rising SCK edge.
  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[i];
      wait_clk(HALF);
      miso_b[i] = spi_miso;
      spi_sck   = 1'b1;
      rise_cyc  = cyc;
      wait_clk(HALF);
      spi_sck   = 1'b0;
    end
  endtask

  task automatic run_vector(input vec_t v);
    logic [7:0] mb;
    int         lat_ref;
    logic [14:0] wr_e;
    logic [6:0]  rd_e;
    wr_q.delete();
    rd_q.delete();
    spi_nss = 1'b0;
    wait_clk(HALF);
    check({v.name, "_active_hi"}, 32'(active), 32'd1);
    check({v.name, "_oe_hi"}, 32'(spi_miso_oe), 32'd1);
    for (int k = 0; k < v.nbytes; k++) begin
      send_bits(v.mosi[k*8 +: 8], 8, mb);
      check($sformatf("%s_miso%0d", v.name, k), 32'(mb), 32'(v.miso[k*8 +: 8]));
    end
    lat_ref = rise_cyc;
    wait_clk(HALF);
    spi_nss = 1'b1;
    wait_clk(HALF);
    check({v.name, "_active_lo"}, 32'(active), 32'd0);
    check({v.name, "_oe_lo"}, 32'(spi_miso_oe), 32'd0);
    // Traffic for another slave on the shared SCK must leave us quiet.
    oe_bad     = 0;
    idle_watch = 1'b1;
    send_bits(8'hA5, 8, mb);
    idle_watch = 1'b0;
    check({v.name, "_idle_oe"}, 32'(oe_bad), 32'd0);
    wait_clk(HALF);
    check({v.name, "_n_wr"}, 32'(wr_q.size()), 32'(v.n_wr));
    check({v.name, "_n_rd"}, 32'(rd_q.size()), 32'(v.n_rd));
    for (int k = 0; k < v.n_wr; k++) begin
      wr_e = (k < wr_q.size()) ? wr_q[k] : 15'h7fff;
      check($sformatf("%s_wr%0d_addr", v.name, k), 32'(wr_e[14:8]), 32'(v.wr_addr[k*8 +: 8]));
      check($sformatf("%s_wr%0d_data", v.name, k), 32'(wr_e[7:0]), 32'(v.wr_data[k*8 +: 8]));
    end
    for (int k = 0; k < v.n_rd; k++) begin
      rd_e = (k < rd_q.size()) ? rd_q[k] : 7'h7f;
      check($sformatf("%s_rd%0d_addr", v.name, k), 32'(rd_e), 32'(v.rd_addr[k*8 +: 8]));
    end
    if (v.n_wr > 0) check({v.name, "_wr_latency"}, 32'(last_wr_cyc - lat_ref), 32'(SS + 2));
    if (v.n_rd > 0) check({v.name, "_rd_latency"}, 32'(last_rd_cyc - lat_ref), 32'(SS + 2));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[5];
    vec_t       post;
    logic [7:0] mb;

    vecs[0] = '{"wr_after_abort", 32'h0000_5A83, 2, 32'h0, 1, 16'h0003, 16'h005A, 0, 24'h0};
    vecs[1] = '{"wr_burst",       32'h0022_1185, 3, 32'h0, 2, 16'h0605, 16'h2211, 0, 24'h0};
    vecs[2] = '{"rd_burst",       32'h0000_0010, 3, 32'h00B1_B000, 0, 16'h0, 16'h0, 3, 24'h12_11_10};
    vecs[3] = '{"wr_wrap",        32'h003C_C3FF, 3, 32'h0, 2, 16'h007F, 16'h3CC3, 0, 24'h0};
    vecs[4] = '{"rd_wrap",        32'h0000_007F, 3, 32'h00A0_1F00, 0, 16'h0, 16'h0, 3, 24'h01_00_7F};
    post    = '{"post_reset",     32'h0000_9984, 2, 32'h0, 1, 16'h0004, 16'h0099, 0, 24'h0};

    wait_clk(3);
    check("reset_outputs", 32'({spi_miso, spi_miso_oe, reg_wr, reg_rd, active, reg_wdata, reg_addr}), 32'd0);
    nreset = 1'b1;
    wait_clk(5);
    check("idle_outputs", 32'({spi_miso, spi_miso_oe, reg_wr, reg_rd, active, reg_wdata, reg_addr}), 32'd0);

    // Abort a write in the middle of its first data byte.
    wr_q.delete();
    spi_nss = 1'b0;
    wait_clk(HALF);
    send_bits(8'h83, 8, mb);
    send_bits(8'h5A, 4, mb);
    wait_clk(HALF);
    spi_nss = 1'b1;
    wait_clk(HALF);
    check("abort_n_wr", 32'(wr_q.size()), 32'd0);
    check("abort_oe", 32'(spi_miso_oe), 32'd0);
    check("abort_active", 32'(active), 32'd0);
    wait_clk(HALF);

    for (int i = 0; i < 5; i++) begin
      run_vector(vecs[i]);
      wait_clk(HALF);
    end

    // Reset during bit 2 of a read data byte, then release with nss still low.
    spi_nss = 1'b0;
    wait_clk(HALF);
    send_bits(8'h20, 8, mb);
    send_bits(8'h00, 2, mb);
    spi_mosi = 1'b1;
    wait_clk(HALF);
    spi_sck = 1'b1;
    wait_clk(3);
    nreset = 1'b0;
    #1;
    check("midreset_outputs", 32'({spi_miso, spi_miso_oe, reg_wr, reg_rd, active, reg_wdata, reg_addr}), 32'd0);
    wait_clk(3);
    spi_sck = 1'b0;
    wait_clk(4);
    nreset = 1'b1;
    wr_q.delete();
    rd_q.delete();
    wait_clk(4);
    send_bits(8'h81, 8, mb);
    wait_clk(HALF);
    check("after_reset_strobes", 32'(wr_q.size() + rd_q.size()), 32'd0);
    check("after_reset_active", 32'(active), 32'd0);
    spi_nss = 1'b1;
    wait_clk(2 * HALF);
    run_vector(post);

    check("strobe_exclusive", 32'(excl_err), 32'd0);
    check("strobe_width", 32'(width_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
